alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the ALU. Captures ALU result and flags, then merges
//  partial-width results into the old destination value using x86-64 width rules. Owns the
//  architectural EFLAGS register, which it feeds back to the ALU as eflags_as_src. Presents
//  one writeback entry to the register file with a valid/ready handshake and forwards it to
//  operand fetch.
// PARAMETERS
//  REG_W       64      datapath / register width
//  REG_ADDR_W  4       GPR index width (16 GPRs)
//  BIT_MODE_W  2       operand-size code width; 0=8b, 1=16b, 2=32b, 3=64b
//  EFLAGS_RST  64'h2   EFLAGS reset value (bit 1 reserved-one)
//  CNT_W       32      retired-micro-op counter width
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rstn           in   1           asynchronous active-low reset
//  flush          in   1           drop held and incoming entries (branch mispredict)
//  in_valid       in   1           ALU result valid this cycle
//  in_ready       out  1           stage can accept
//  in_d           in   REG_W       ALU result (low bits significant per bit_mode)
//  in_eflags      in   REG_W       ALU-computed EFLAGS
//  in_old_d       in   REG_W       current destination register value
//  in_bit_mode    in   BIT_MODE_W  operand size of the micro-op
//  in_dst         in   REG_ADDR_W  destination GPR
//  in_wr_reg      in   1           micro-op writes a GPR
//  in_wr_flags    in   1           micro-op updates EFLAGS
//  eflags_as_src  out  REG_W       committed EFLAGS, to ALU
//  wb_valid       out  1           writeback entry valid
//  wb_ready       in   1           register file accepts
//  wb_dst         out  REG_ADDR_W  writeback GPR index
//  wb_data        out  REG_W       merged writeback value
//  fwd_valid      out  1           wb_valid & held entry writes a GPR
//  retired        out  CNT_W       count of micro-ops leaving the stage
// BEHAVIOUR
//  Reset (async, rstn=0): wb_valid=0, wb_dst=0, wb_data=0, eflags_as_src=EFLAGS_RST,
//   retired=0. All outputs are registered except in_ready and fwd_valid (combinational).
//  Handshake: in_ready = ~wb_valid | wb_ready | flush. Accept when in_valid & in_ready & ~flush.
//   Fire when wb_valid & wb_ready.
//  Latency: 1 cycle from accept to wb_valid=1. Full throughput when wb_ready is held high.
//  Entry state: EMPTY (wb_valid=0) and FULL (wb_valid=1).
//   EMPTY -> FULL on accept.
//   FULL stays FULL on fire+accept (entry replaced same edge).
//   FULL -> EMPTY on fire without accept.
//   FULL holds all fields stable while wb_ready=0.
//   flush=1 forces EMPTY next edge, and overrides accept/fire.
//  Entries with in_wr_reg=0 still occupy the stage: wb_valid=1, wb_dst=in_dst, wb_data=merged.
//   The register file ignores them via fwd_valid=0. A wr_reg bit is held internally.
//  Width merge (wb_data on accept):
//   8b  {in_old_d[63:8], in_d[7:0]}
//   16b {in_old_d[63:16], in_d[15:0]}
//   32b {32'b0, in_d[31:0]} (zero-extend; old value ignored)
//   64b in_d
//  EFLAGS: on accept with in_wr_flags=1, the register takes in_eflags, except bit 1 is forced
//   to 1. It is visible on eflags_as_src the next cycle, for back-to-back dependent ops.
//   No update on flush cycles, on in_wr_flags=0, or when not accepted.
//  retired increments by 1 on each fire not coinciding with flush. It saturates at all-ones.
//  Reset mid-operation: the held entry is discarded and EFLAGS returns to EFLAGS_RST
//   immediately.
// TESTING
//  1 reset: rstn=0 mid-stream -> wb_valid=0, eflags_as_src=64'h2, retired=0 same cycle.
//  2 8b merge: old=64'h1122334455667788, d=64'hAB, mode=0, dst=3
//    -> next cycle wb_valid=1, wb_data=64'h11223344556677AB, wb_dst=3.
//  3 32b zero-extend: old=64'hFFFFFFFF00000000, d=64'h1_2345_6789, mode=2
//    -> wb_data=64'h0000000023456789.
//  4 backpressure: wb_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, wb_* stable.
//    wb_ready=1 -> one fire, next entry accepted same edge, retired +1.
//  5 flags: accept wr_flags=1, in_eflags=64'h40 (ZF) -> eflags_as_src=64'h42 next cycle.
//    A following op with wr_flags=0 -> eflags unchanged.
//  6 flush: FULL entry with flush=1 and in_valid=1 -> wb_valid=0 next cycle, EFLAGS unchanged,
//    retired unchanged.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result stage: merges partial-width results into the old destination value,
// owns architectural EFLAGS and presents one writeback entry with a valid/ready handshake.
module alu_result_stage #(
  parameter int               REG_W      = 64,
  parameter int               REG_ADDR_W = 4,
  parameter int               BIT_MODE_W = 2,
  parameter logic [REG_W-1:0] EFLAGS_RST = REG_W'(2),
  parameter int               CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_W-1:0]      in_d,
  input  logic [REG_W-1:0]      in_eflags,
  input  logic [REG_W-1:0]      in_old_d,
  input  logic [BIT_MODE_W-1:0] in_bit_mode,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic                  in_wr_reg,
  input  logic                  in_wr_flags,
  output logic [REG_W-1:0]      eflags_as_src,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic [REG_W-1:0]      wb_data,
  output logic                  fwd_valid,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } entry_state_e;

  entry_state_e          state_q, state_d;
  logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic [REG_W-1:0]      wb_data_q, wb_data_d;
  logic                  wr_reg_q, wr_reg_d;
  logic [REG_W-1:0]      eflags_q, eflags_d;
  logic [CNT_W-1:0]      retired_q, retired_d;
  logic                  accept_s;
  logic                  fire_s;

  // x86-64 width rules: 8/16-bit writes keep upper old bits, 32-bit writes zero-extend.
  function automatic logic [REG_W-1:0] merge_width(
    input logic [BIT_MODE_W-1:0] mode,
    input logic [REG_W-1:0]      d,
    input logic [REG_W-1:0]      old
  );
    logic [REG_W-1:0] r;
    case (mode)
      BIT_MODE_W'(0): r = {old[REG_W-1:8], d[7:0]};
      BIT_MODE_W'(1): r = {old[REG_W-1:16], d[15:0]};
      BIT_MODE_W'(2): r = {{(REG_W-32){1'b0}}, d[31:0]};
      default:        r = d;
    endcase
    return r;
  endfunction

  assign in_ready      = (state_q == ST_EMPTY) | wb_ready | flush;
  assign accept_s      = in_valid & in_ready & ~flush;
  assign fire_s        = (state_q == ST_FULL) & wb_ready;
  assign wb_valid      = (state_q == ST_FULL);
  assign wb_dst        = wb_dst_q;
  assign wb_data       = wb_data_q;
  assign eflags_as_src = eflags_q;
  assign retired       = retired_q;
  assign fwd_valid     = wb_valid & wr_reg_q;

  // Next-state selection for the entry, EFLAGS and retire counter.
  always_comb begin
    state_d   = state_q;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    wr_reg_d  = wr_reg_q;
    eflags_d  = eflags_q;
    retired_d = retired_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept_s) begin
      state_d   = ST_FULL;
      wb_dst_d  = in_dst;
      wb_data_d = merge_width(in_bit_mode, in_d, in_old_d);
      wr_reg_d  = in_wr_reg;
    end else if (fire_s) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end

    // Bit 1 of EFLAGS is reserved and always reads as one.
    if (accept_s && in_wr_flags) begin
      eflags_d = {in_eflags[REG_W-1:2], 1'b1, in_eflags[0]};
    end else begin
      eflags_d = eflags_q;
    end

    if (fire_s && !flush && !(&retired_q)) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_EMPTY;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      wr_reg_q  <= 1'b0;
      eflags_q  <= EFLAGS_RST;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      wr_reg_q  <= wr_reg_d;
      eflags_q  <= eflags_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a randomized run
// against a behavioural model of the handshake, width merge, EFLAGS and retire count.
module tb_alu_result_stage;

  localparam int TB_CNT_W = 4;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_d;
  logic [63:0] in_eflags;
  logic [63:0] in_old_d;
  logic [1:0]  in_bit_mode;
  logic [3:0]  in_dst;
  logic        in_wr_reg;
  logic        in_wr_flags;
  logic [63:0] eflags_as_src;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_dst;
  logic [63:0] wb_data;
  logic        fwd_valid;
  logic [TB_CNT_W-1:0] retired;

  int checks;
  int failures;

  // Reference model state
  logic        m_valid;
  logic [3:0]  m_dst;
  logic [63:0] m_data;
  logic        m_wr;
  logic [63:0] m_flags;
  int          m_ret;

  alu_result_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_eflags(in_eflags),
    .in_old_d(in_old_d), .in_bit_mode(in_bit_mode), .in_dst(in_dst),
    .in_wr_reg(in_wr_reg), .in_wr_flags(in_wr_flags), .eflags_as_src(eflags_as_src),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_merge(input logic [1:0] mode, input logic [63:0] d,
                                              input logic [63:0] old);
    logic [63:0] m8;
    logic [63:0] m16;
    logic [63:0] m32;
    m8  = 64'hFF;
    m16 = 64'hFFFF;
    m32 = 64'hFFFF_FFFF;
    case (mode)
      2'd0:    return (old & ~m8) | (d & m8);
      2'd1:    return (old & ~m16) | (d & m16);
      2'd2:    return d & m32;
      default: return d;
    endcase
  endfunction

  function automatic logic model_ready();
    return !m_valid || wb_ready || flush;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_dst = 4'd0; m_data = 64'd0; m_wr = 1'b0;
    m_flags = 64'h2; m_ret = 0;
  endtask

  // Advance one clock and move the model with the inputs present before the edge.
  task automatic tick();
    logic acc, fire, nv, nwr;
    logic [3:0] ndst;
    logic [63:0] ndata, nflags;
    int nret;
    acc = in_valid && model_ready() && !flush;
    fire = m_valid && wb_ready;
    nv = m_valid; ndst = m_dst; ndata = m_data; nwr = m_wr; nflags = m_flags; nret = m_ret;
    if (flush) nv = 1'b0;
    else if (acc) begin
      nv = 1'b1; ndst = in_dst; ndata = model_merge(in_bit_mode, in_d, in_old_d); nwr = in_wr_reg;
    end else if (fire) nv = 1'b0;
    if (acc && in_wr_flags) nflags = in_eflags | 64'h2;
    if (fire && !flush && m_ret < (1 << TB_CNT_W) - 1) nret = m_ret + 1;
    @(posedge clk);
    #1;
    m_valid = nv; m_dst = ndst; m_data = ndata; m_wr = nwr; m_flags = nflags; m_ret = nret;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [63:0] old,
                       input logic [1:0] mode, input logic [3:0] dst, input logic wr,
                       input logic wf, input logic [63:0] fl);
    in_valid = v; in_d = d; in_old_d = old; in_bit_mode = mode; in_dst = dst;
    in_wr_reg = wr; in_wr_flags = wf; in_eflags = fl;
  endtask

  task automatic test_reset_values();
    checks++;
    if (wb_valid !== 1'b0 || wb_dst !== 4'd0 || wb_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_entry: valid=%b dst=%0d data=%h, want 0/0/0", wb_valid, wb_dst, wb_data);
    end
    checks++;
    if (eflags_as_src !== 64'h2 || retired !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: eflags=%h retired=%0d, want 2/0", eflags_as_src, retired);
    end
  endtask

  task automatic test_merge_8b();
    wb_ready = 1'b1; flush = 1'b0;
    drive(1'b1, 64'hAB, 64'h1122334455667788, 2'd0, 4'd3, 1'b1, 1'b0, 64'h0);
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 64'h11223344556677AB || wb_dst !== 4'd3) begin
      failures++;
      $display("FAIL merge_8b: valid=%b data=%h dst=%0d, want 1/11223344556677ab/3",
               wb_valid, wb_data, wb_dst);
    end
    checks++;
    if (fwd_valid !== 1'b1) begin
      failures++;
      $display("FAIL fwd_valid_wr: got %b want 1", fwd_valid);
    end
  endtask

  task automatic test_zero_extend_32b();
    drive(1'b1, 64'h1_2345_6789, 64'hFFFFFFFF00000000, 2'd2, 4'd5, 1'b1, 1'b0, 64'h0);
    tick();
    checks++;
    if (wb_data !== 64'h0000000023456789 || wb_dst !== 4'd5 || retired !== 4'd1) begin
      failures++;
      $display("FAIL zext_32b: data=%h dst=%0d retired=%0d, want 0000000023456789/5/1",
               wb_data, wb_dst, retired);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [3:0]  held_dst;
    logic [TB_CNT_W-1:0] ret0;
    held = wb_data; held_dst = wb_dst; ret0 = retired;
    wb_ready = 1'b0;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'hAAAA_BBBB_CCCC_DDDD, 2'd1, 4'd7, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== held || wb_dst !== held_dst || retired !== ret0) begin
        failures++;
        $display("FAIL bp_stable[%0d]: valid=%b data=%h dst=%0d ret=%0d, want 1/%h/%0d/%0d",
                 i, wb_valid, wb_data, wb_dst, retired, held, held_dst, ret0);
      end
    end
    wb_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (wb_data !== 64'hAAAABBBBCCCCDEF0 || wb_dst !== 4'd7 || retired !== ret0 + 4'd1) begin
      failures++;
      $display("FAIL bp_release: data=%h dst=%0d ret=%0d, want aaaabbbbccccdef0/7/%0d",
               wb_data, wb_dst, retired, ret0 + 4'd1);
    end
  endtask

  task automatic test_flags();
    drive(1'b1, 64'h5, 64'h0, 2'd3, 4'd1, 1'b1, 1'b1, 64'h40);
    tick();
    checks++;
    if (eflags_as_src !== 64'h42 || wb_data !== 64'h5) begin
      failures++;
      $display("FAIL flags_update: eflags=%h data=%h, want 42/5", eflags_as_src, wb_data);
    end
    drive(1'b1, 64'h6, 64'h0, 2'd3, 4'd2, 1'b0, 1'b0, 64'hFFFF);
    tick();
    checks++;
    if (eflags_as_src !== 64'h42) begin
      failures++;
      $display("FAIL flags_hold: eflags=%h want 42", eflags_as_src);
    end
    checks++;
    if (wb_valid !== 1'b1 || fwd_valid !== 1'b0 || wb_dst !== 4'd2) begin
      failures++;
      $display("FAIL no_wr_reg: valid=%b fwd=%b dst=%0d, want 1/0/2", wb_valid, fwd_valid, wb_dst);
    end
  endtask

  task automatic test_flush();
    logic [TB_CNT_W-1:0] ret0;
    ret0 = retired;
    flush = 1'b1; wb_ready = 1'b1;
    drive(1'b1, 64'h77, 64'h0, 2'd3, 4'd9, 1'b1, 1'b1, 64'h80);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || eflags_as_src !== 64'h42 || retired !== ret0) begin
      failures++;
      $display("FAIL flush: valid=%b eflags=%h ret=%0d, want 0/42/%0d",
               wb_valid, eflags_as_src, retired, ret0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(7) == 0);
      wb_ready = $urandom_range(1);
      drive($urandom_range(3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom_range(3)), 4'($urandom_range(15)), $urandom_range(1),
            $urandom_range(1), {$urandom, $urandom});
      #1;
      checks++;
      if (in_ready !== model_ready() || fwd_valid !== (m_valid && m_wr)) begin
        failures++;
        $display("FAIL rand_comb[%0d]: in_ready=%b fwd=%b, want %b/%b",
                 i, in_ready, fwd_valid, model_ready(), m_valid && m_wr);
      end
      tick();
      checks++;
      if (wb_valid !== m_valid || wb_dst !== m_dst || wb_data !== m_data ||
          eflags_as_src !== m_flags || retired !== TB_CNT_W'(m_ret)) begin
        failures++;
        $display("FAIL rand_state[%0d]: v=%b dst=%0d data=%h fl=%h ret=%0d, want %b/%0d/%h/%h/%0d",
                 i, wb_valid, wb_dst, wb_data, eflags_as_src, retired,
                 m_valid, m_dst, m_data, m_flags, m_ret);
      end
    end
    checks++;
    if (retired !== 4'hF) begin
      failures++;
      $display("FAIL retired_saturate: got %0d want 15", retired);
    end
  endtask

  task automatic test_reset_midstream();
    flush = 1'b0; wb_ready = 1'b0;
    drive(1'b1, 64'h99, 64'h0, 2'd3, 4'd4, 1'b1, 1'b1, 64'h8C1);
    tick();
    rstn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (wb_valid !== 1'b0 || eflags_as_src !== 64'h2 || retired !== 4'd0 || fwd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_midstream: valid=%b eflags=%h ret=%0d fwd=%b, want 0/2/0/0",
               wb_valid, eflags_as_src, retired, fwd_valid);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    test_reset_values();
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 2'd0, 4'd0, 1'b0, 1'b0, 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    test_reset_values();
    test_merge_8b();
    test_zero_extend_32b();
    test_backpressure();
    test_flags();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
